// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified main-memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int unsigned WORDS_PER_BLK = 8;
   localparam int unsigned BLK_OFF_W     = 4;
   localparam int unsigned WORD_IDX_W    = 3;
   localparam int unsigned ISSUE_CNT_W   = WORD_IDX_W + 1;
   localparam int unsigned STATE_W       = 2;

   localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
   localparam logic [STATE_W-1:0] ST_FILL_D = 2'd1;
   localparam logic [STATE_W-1:0] ST_FILL_I = 2'd2;

   // Byte offset of a 16-bit word inside its block.
   function automatic logic [BLK_OFF_W-1:0] word_byte_off(input logic [WORD_IDX_W-1:0] idx);
      return {idx, 1'b0};
   endfunction

endpackage

// File: rtl/mem_port_arbiter_fill_seq_counter.sv
// Issue/receive counter pair sequencing one block fill.
module mem_port_arbiter_fill_seq_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned WORDS = WORDS_PER_BLK
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_clr,
   input  logic                  i_issue,
   input  logic                  i_recv,
   output logic [WORD_IDX_W-1:0] o_issue_idx,
   output logic [WORD_IDX_W-1:0] o_recv_idx,
   output logic                  o_issue_done_c,
   output logic                  o_recv_last_c
);

   logic [ISSUE_CNT_W-1:0] r_issue_cnt;
   logic [WORD_IDX_W-1:0]  r_recv_cnt;

   // Count issued addresses (saturating at a full block) and returned words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_issue_cnt <= '0;
         r_recv_cnt  <= '0;
      end else if (i_clr) begin
         r_issue_cnt <= '0;
         r_recv_cnt  <= '0;
      end else begin
         if (i_issue && !o_issue_done_c)
            r_issue_cnt <= r_issue_cnt + ISSUE_CNT_W'(1);
         if (i_recv)
            r_recv_cnt <= r_recv_cnt + WORD_IDX_W'(1);
      end
   end

   assign o_issue_idx    = r_issue_cnt[WORD_IDX_W-1:0];
   assign o_recv_idx     = r_recv_cnt;
   assign o_issue_done_c = (r_issue_cnt == ISSUE_CNT_W'(WORDS));
   assign o_recv_last_c  = (r_recv_cnt == WORD_IDX_W'(WORDS - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Owner of the main-memory port: I/D block fills and D-side write-through stores.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W        = 16,
   parameter int unsigned WORDS_PER_BLK = mem_port_arbiter_pkg::WORDS_PER_BLK
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_miss,
   input  logic [ADDR_W-1:0]     i_miss_addr,
   input  logic                  d_miss,
   input  logic [ADDR_W-1:0]     d_miss_addr,
   input  logic                  st_req,
   input  logic [ADDR_W-1:0]     st_addr,
   input  logic                  mem_valid,
   output logic                  mem_en,
   output logic                  mem_wr,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [WORD_IDX_W-1:0] fill_word,
   output logic                  i_data_we,
   output logic                  i_tag_we,
   output logic                  d_data_we,
   output logic                  d_tag_we,
   output logic                  i_stall,
   output logic                  d_stall
);

   localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((32'd1 << BLK_OFF_W) - 32'd1);

   logic [STATE_W-1:0]    r_state;
   logic [STATE_W-1:0]    w_state_nxt;
   logic [ADDR_W-1:0]     r_base;
   logic [ADDR_W-1:0]     w_base_nxt;
   logic                  w_clr;
   logic                  w_issue;
   logic                  w_recv;
   logic [WORD_IDX_W-1:0] w_issue_idx;
   logic [WORD_IDX_W-1:0] w_recv_idx;
   logic                  w_issue_done;
   logic                  w_recv_last;

   mem_port_arbiter_fill_seq_counter #(
      .WORDS (WORDS_PER_BLK)
   ) u_fill_seq_counter (
      .clk            (clk),
      .rst            (rst),
      .i_clr          (w_clr),
      .i_issue        (w_issue),
      .i_recv         (w_recv),
      .o_issue_idx    (w_issue_idx),
      .o_recv_idx     (w_recv_idx),
      .o_issue_done_c (w_issue_done),
      .o_recv_last_c  (w_recv_last)
   );

   // State and latched block base.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_base  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_base  <= w_base_nxt;
      end
   end

   // Arbitration, fill sequencing and port/strobe drive; everything quiet under reset.
   always_comb begin
      w_state_nxt = r_state;
      w_base_nxt  = r_base;
      w_clr       = 1'b0;
      w_issue     = 1'b0;
      w_recv      = 1'b0;
      mem_en      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      fill_word   = '0;
      i_data_we   = 1'b0;
      i_tag_we    = 1'b0;
      d_data_we   = 1'b0;
      d_tag_we    = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_IDLE: begin
               w_clr = 1'b1;
               if (st_req) begin
                  mem_en   = 1'b1;
                  mem_wr   = 1'b1;
                  mem_addr = st_addr;
               end else if (d_miss) begin
                  w_state_nxt = ST_FILL_D;
                  w_base_nxt  = d_miss_addr & BLK_MASK;
               end else if (i_miss) begin
                  w_state_nxt = ST_FILL_I;
                  w_base_nxt  = i_miss_addr & BLK_MASK;
               end
            end
            ST_FILL_D, ST_FILL_I: begin
               if (!w_issue_done) begin
                  mem_en   = 1'b1;
                  mem_addr = r_base + ADDR_W'(word_byte_off(w_issue_idx));
                  w_issue  = 1'b1;
               end
               if (mem_valid) begin
                  w_recv    = 1'b1;
                  fill_word = w_recv_idx;
                  if (r_state == ST_FILL_D) begin
                     d_data_we = 1'b1;
                     d_tag_we  = w_recv_last;
                  end else begin
                     i_data_we = 1'b1;
                     i_tag_we  = w_recv_last;
                  end
                  if (w_recv_last)
                     w_state_nxt = ST_IDLE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Stalls hold a side while its miss is pending, its fill runs, or a store waits out a fill.
   assign i_stall = i_miss | (r_state == ST_FILL_I);
   assign d_stall = d_miss | (r_state == ST_FILL_D) | (st_req & (r_state != ST_IDLE));

   // Memory returns are only legal while a fill is outstanding.
   a_no_idle_return: assert property (@(posedge clk) disable iff (rst)
      !(mem_valid && (r_state == ST_IDLE)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: transaction-level arbiter model plus directed literal checks.
module tb_mem_port_arbiter;

   logic        clk, rst, i_miss, d_miss, st_req, mem_valid;
   logic [15:0] i_miss_addr, d_miss_addr, st_addr, mem_addr;
   logic        mem_en, mem_wr, i_data_we, i_tag_we, d_data_we, d_tag_we, i_stall, d_stall;
   logic [2:0]  fill_word;

   mem_port_arbiter #(.ADDR_W(16), .WORDS_PER_BLK(8)) dut (
      .clk(clk), .rst(rst), .i_miss(i_miss), .i_miss_addr(i_miss_addr),
      .d_miss(d_miss), .d_miss_addr(d_miss_addr), .st_req(st_req), .st_addr(st_addr),
      .mem_valid(mem_valid), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .fill_word(fill_word), .i_data_we(i_data_we), .i_tag_we(i_tag_we),
      .d_data_we(d_data_we), .d_tag_we(d_tag_we), .i_stall(i_stall), .d_stall(d_stall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // Requester / memory environment state
   logic        rst_drv, d_req, i_req, s_req;
   logic [15:0] d_addr, i_addr, s_addr;
   bit          rand_gaps, gap_at3;
   int          gap_cnt;
   int          mem_q[$];

   // Behavioural model: who owns the port, addresses still to issue, words returned
   int          m_owner;   // 0 none, 1 D-side fill, 2 I-side fill
   int          m_ret;
   logic [15:0] m_iss_q[$];

   // Observations for literal checks
   int          iss_t[$];
   logic [15:0] iss_a[$];
   int          dtag_t[$], itag_t[$], st_t[$];
   logic [15:0] st_a[$];
   logic [2:0]  fw_q[$];
   int          ilow, dlow;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic clr_obs();
      iss_t.delete(); iss_a.delete(); dtag_t.delete(); itag_t.delete();
      st_t.delete(); st_a.delete(); fw_q.delete();
      ilow = 0; dlow = 0;
   endtask

   // One clock cycle: drive, predict, compare, observe.
   task automatic step();
      logic        e_en, e_wr, e_idwe, e_itwe, e_ddwe, e_dtwe, e_ist, e_dst;
      logic [15:0] e_addr, blk;
      logic [2:0]  e_fw;
      @(negedge clk);
      cyc++;
      rst = rst_drv;
      d_miss = d_req; d_miss_addr = d_addr;
      i_miss = i_req; i_miss_addr = i_addr;
      st_req = s_req; st_addr = s_addr;
      if (rst_drv) mem_q.delete();
      mem_valid = 1'b0;
      if (!rst_drv && mem_q.size() > 0 && mem_q[0] + 4 <= cyc) begin
         if (gap_cnt > 0) gap_cnt--;
         else if (rand_gaps && $urandom_range(0, 3) == 0) gap_cnt = 0;
         else begin
            mem_valid = 1'b1;
            void'(mem_q.pop_front());
         end
      end
      #1;
      if (rst_drv) begin
         m_owner = 0; m_ret = 0; m_iss_q.delete();
      end
      e_en = 0; e_wr = 0; e_addr = '0; e_fw = '0;
      e_idwe = 0; e_itwe = 0; e_ddwe = 0; e_dtwe = 0;
      e_ist = i_miss | (m_owner == 2);
      e_dst = d_miss | (m_owner == 1) | (st_req && m_owner != 0);
      if (!rst_drv) begin
         if (m_owner == 0) begin
            if (st_req) begin
               e_en = 1; e_wr = 1; e_addr = st_addr;
            end else if (d_miss || i_miss) begin
               m_owner = d_miss ? 1 : 2;
               blk = d_miss ? d_miss_addr : i_miss_addr;
               blk = {blk[15:4], 4'h0};
               m_ret = 0;
               for (int k = 0; k < 8; k++) m_iss_q.push_back(blk + 16'(2 * k));
            end
         end else begin
            if (m_iss_q.size() > 0) begin
               e_en = 1; e_addr = m_iss_q.pop_front();
            end
            if (mem_valid) begin
               e_fw = 3'(m_ret);
               if (m_owner == 1) begin e_ddwe = 1; e_dtwe = (m_ret == 7); end
               else              begin e_idwe = 1; e_itwe = (m_ret == 7); end
               if (m_ret == 7) m_owner = 0;
               m_ret++;
            end
         end
      end
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("mem_wr", 32'(mem_wr), 32'(e_wr));
      if (e_en) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("i_data_we", 32'(i_data_we), 32'(e_idwe));
      chk("i_tag_we", 32'(i_tag_we), 32'(e_itwe));
      chk("d_data_we", 32'(d_data_we), 32'(e_ddwe));
      chk("d_tag_we", 32'(d_tag_we), 32'(e_dtwe));
      if (e_idwe || e_ddwe) chk("fill_word", 32'(fill_word), 32'(e_fw));
      chk("i_stall", 32'(i_stall), 32'(e_ist));
      chk("d_stall", 32'(d_stall), 32'(e_dst));
      // Environment reacts to what the DUT actually did
      if (i_miss && !i_stall) ilow++;
      if (st_req && !d_stall && !(mem_en && mem_wr)) dlow++;
      if (mem_en && !mem_wr) begin
         mem_q.push_back(cyc); iss_t.push_back(cyc); iss_a.push_back(mem_addr);
      end
      if (mem_en && mem_wr) begin
         st_t.push_back(cyc); st_a.push_back(mem_addr); s_req = 1'b0;
      end
      if (d_data_we || i_data_we) begin
         fw_q.push_back(fill_word);
         if (gap_at3 && fill_word == 3'd2) gap_cnt = 2;
      end
      if (d_tag_we) begin dtag_t.push_back(cyc); d_req = 1'b0; end
      if (i_tag_we) begin itag_t.push_back(cyc); i_req = 1'b0; end
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int n;
      n = 0;
      while (!(m_owner == 0 && !d_req && !i_req && !s_req && mem_q.size() == 0)) begin
         if (n >= budget) begin
            n_chk++; n_fail++;
            $display("FAIL %s timeout after %0d cycles", nm, budget);
            d_req = 0; i_req = 0; s_req = 0;
            break;
         end
         step();
         n++;
      end
   endtask

   task automatic chk_fw_order(input string nm);
      chk({nm, "_cnt"}, 32'(fw_q.size()), 32'd8);
      for (int k = 0; k < 8; k++)
         chk(nm, (k < fw_q.size()) ? 32'(fw_q[k]) : 32'hFFFF, 32'(k));
   endtask

   initial begin
      int n0;
      rst = 1'b1; rst_drv = 1'b1;
      d_req = 0; i_req = 0; s_req = 0; d_addr = '0; i_addr = '0; s_addr = '0;
      d_miss = 0; i_miss = 0; st_req = 0; mem_valid = 0;
      d_miss_addr = '0; i_miss_addr = '0; st_addr = '0;
      rand_gaps = 0; gap_at3 = 0; gap_cnt = 0;
      m_owner = 0; m_ret = 0;
      clr_obs();

      // Reset state
      step(); step();
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_stalls", 32'({i_stall, d_stall}), 32'd0);
      rst_drv = 1'b0;
      step();

      // D miss at 0x1236
      clr_obs();
      d_req = 1; d_addr = 16'h1236;
      step(); n0 = cyc;
      wait_idle(100, "dmiss_wait");
      chk("dmiss_first_t", 32'(iss_t[0] - n0), 32'd1);
      chk("dmiss_first_a", 32'(iss_a[0]), 32'h1230);
      chk("dmiss_last_t", 32'(iss_t[7] - n0), 32'd8);
      chk("dmiss_last_a", 32'(iss_a[7]), 32'h123E);
      chk("dmiss_tag_t", 32'(dtag_t[0] - n0), 32'd12);
      chk_fw_order("dmiss_fw");
      step();
      chk("dmiss_stall_n13", 32'(d_stall), 32'd0);
      chk("dmiss_n13", 32'(cyc - n0), 32'd13);

      // Dual miss: D first, I starts right after
      clr_obs();
      d_req = 1; d_addr = 16'h0040; i_req = 1; i_addr = 16'h2000;
      step(); n0 = cyc;
      wait_idle(100, "dual_wait");
      chk("dual_dtag_t", 32'(dtag_t[0] - n0), 32'd12);
      chk("dual_d_first_a", 32'(iss_a[0]), 32'h0040);
      chk("dual_i_first_t", 32'(iss_t[8] - n0), 32'd14);
      chk("dual_i_first_a", 32'(iss_a[8]), 32'h2000);
      chk("dual_i_last_t", 32'(iss_t[15] - n0), 32'd21);
      chk("dual_i_last_a", 32'(iss_a[15]), 32'h200E);
      chk("dual_itag_t", 32'(itag_t[0] - n0), 32'd25);
      chk("dual_istall_low", 32'(ilow), 32'd0);

      // Store in IDLE: same-cycle write, no stall
      clr_obs();
      s_req = 1; s_addr = 16'h0102;
      step();
      chk("st_idle_en", 32'(mem_en), 32'd1);
      chk("st_idle_wr", 32'(mem_wr), 32'd1);
      chk("st_idle_addr", 32'(mem_addr), 32'h0102);
      chk("st_idle_dstall", 32'(d_stall), 32'd0);

      // Store arriving during an I fill waits for IDLE
      clr_obs();
      i_req = 1; i_addr = 16'h3004;
      step(); n0 = cyc;
      step(); step();
      s_req = 1; s_addr = 16'h0204;
      step();
      wait_idle(100, "st_fill_wait");
      chk("st_fill_t", 32'(st_t[0] - n0), 32'd13);
      chk("st_fill_a", 32'(st_a[0]), 32'h0204);
      chk("st_fill_dstall_low", 32'(dlow), 32'd0);
      chk("st_fill_cnt", 32'(st_t.size()), 32'd1);

      // Two-cycle gap between returns 3 and 4
      clr_obs();
      gap_at3 = 1;
      d_req = 1; d_addr = 16'h4A5C;
      step(); n0 = cyc;
      wait_idle(100, "gap_wait");
      gap_at3 = 0;
      chk_fw_order("gap_fw");
      chk("gap_tag_cnt", 32'(dtag_t.size()), 32'd1);
      chk("gap_tag_t", 32'(dtag_t[0] - n0), 32'd14);

      // Reset mid-fill at N+7, then refill from scratch
      clr_obs();
      d_req = 1; d_addr = 16'h5678;
      step(); n0 = cyc;
      repeat (6) step();
      rst_drv = 1'b1;
      step();
      chk("rstmid_mem_en", 32'(mem_en), 32'd0);
      chk("rstmid_dwe", 32'({d_data_we, d_tag_we}), 32'd0);
      chk("rstmid_dstall", 32'(d_stall), 32'd1);
      chk("rstmid_tag_none", 32'(dtag_t.size()), 32'd0);
      clr_obs();
      rst_drv = 1'b0;
      wait_idle(100, "rstmid_wait");
      chk("rstmid_re_first_t", 32'(iss_t[0] - n0), 32'd9);
      chk("rstmid_re_first_a", 32'(iss_a[0]), 32'h5670);
      chk("rstmid_tag_cnt", 32'(dtag_t.size()), 32'd1);
      chk("rstmid_tag_t", 32'(dtag_t[0] - n0), 32'd20);
      chk_fw_order("rstmid_fw");

      // Randomized traffic with return gaps and occasional resets
      rand_gaps = 1;
      for (int k = 0; k < 3000; k++) begin
         rst_drv = ($urandom_range(0, 799) == 0);
         if (!d_req && !s_req && $urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1) begin s_req = 1; s_addr = 16'($urandom); end
            else begin d_req = 1; d_addr = 16'($urandom); end
         end
         if (!i_req && $urandom_range(0, 7) == 0) begin
            i_req = 1; i_addr = 16'($urandom);
         end
         step();
      end
      rst_drv = 1'b0;
      wait_idle(400, "rand_drain");
      rand_gaps = 0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
